// File: rtl/vga_area_tracker.sv
// vga_area_tracker
//   Free-running VGA raster timing generator. A horizontal (pixel) counter
//   and a vertical (line) counter are the only state. Every output is a
//   combinational decode of those two counters, so outputs have zero latency
//   relative to the counters.
//
//   Each axis is laid out as: visible -> front porch -> sync -> back porch.
//
// Ports
//   i_clk        pixel clock; all logic runs on the rising edge
//   i_rst        asynchronous, active-high reset; returns the raster to (0,0)
//   o_h_sync     horizontal sync; SYNC_ACTIVE during the h sync pulse
//   o_v_sync     vertical sync; SYNC_ACTIVE during the v sync pulse
//   o_visible    high when both counters are in their visible regions
//   o_x          current pixel column while visible, else 0
//   o_y          current line while visible, else 0
//   o_line_end   high on the last pixel of every line
//   o_frame_end  high on the last pixel of the last line of the frame
module vga_area_tracker #(
  parameter int CNT_WIDTH     = 10,
  parameter int H_VISIBLE     = 640,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_SYNC        = 96,
  parameter int H_FRONT_PORCH = 16,
  parameter int V_VISIBLE     = 480,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_SYNC        = 2,
  parameter int V_FRONT_PORCH = 10,
  parameter bit SYNC_ACTIVE   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_h_sync,
  output logic                 o_v_sync,
  output logic                 o_visible,
  output logic [CNT_WIDTH-1:0] o_x,
  output logic [CNT_WIDTH-1:0] o_y,
  output logic                 o_line_end,
  output logic                 o_frame_end
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  // Region boundaries are precomputed at counter width. Sync bounds are kept
  // inclusive so that a zero back porch (sync ending on the last count) never
  // needs a value one past the counter range.
  localparam logic [CNT_WIDTH-1:0] H_LAST       = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_VIS_LIMIT  = CNT_WIDTH'(H_VISIBLE);
  localparam logic [CNT_WIDTH-1:0] H_SYNC_FIRST = CNT_WIDTH'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [CNT_WIDTH-1:0] H_SYNC_LAST  = CNT_WIDTH'(H_VISIBLE + H_FRONT_PORCH + H_SYNC - 1);

  localparam logic [CNT_WIDTH-1:0] V_LAST       = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_VIS_LIMIT  = CNT_WIDTH'(V_VISIBLE);
  localparam logic [CNT_WIDTH-1:0] V_SYNC_FIRST = CNT_WIDTH'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [CNT_WIDTH-1:0] V_SYNC_LAST  = CNT_WIDTH'(V_VISIBLE + V_FRONT_PORCH + V_SYNC - 1);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_h_cnt;
  logic [CNT_WIDTH-1:0] r_v_cnt;

  logic w_h_last;
  logic w_v_last;
  logic w_h_visible;
  logic w_v_visible;
  logic w_h_in_sync;
  logic w_v_in_sync;
  logic w_visible;

  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_h_visible = (r_h_cnt < H_VIS_LIMIT);
  assign w_v_visible = (r_v_cnt < V_VIS_LIMIT);
  assign w_h_in_sync = (r_h_cnt >= H_SYNC_FIRST) && (r_h_cnt <= H_SYNC_LAST);
  assign w_v_in_sync = (r_v_cnt >= V_SYNC_FIRST) && (r_v_cnt <= V_SYNC_LAST);
  assign w_visible   = w_h_visible && w_v_visible;

  // Raster counters. The line counter only moves on the pixel that ends a
  // line, so on the very last pixel of the frame both counters wrap to zero
  // on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : (r_v_cnt + CNT_ONE);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_ONE;
    end
  end

  // Coordinates are forced to zero outside the visible window so downstream
  // pixel logic can use them directly as an address without extra gating.
  assign o_h_sync    = w_h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_v_sync    = w_v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_visible   = w_visible;
  assign o_x         = w_visible ? r_h_cnt : '0;
  assign o_y         = w_visible ? r_v_cnt : '0;
  assign o_line_end  = w_h_last;
  assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: tb/tb_vga_area_tracker.sv
// tb_vga_area_tracker
//   Directed bench for vga_area_tracker. Four instances share one clock and
//   one reset:
//     u_small : H 1/4/3/2, V 2/1/1/1, active-low sync (10-pixel line, 5-line frame)
//     u_vga   : default 640x480 timing
//     u_vtall : H 1/0/1/0 (zero porches, 2-pixel line) with default V timing,
//               so the full 525-line vertical sequence fits in a short run
//     u_sa    : H 4/0/3/2, V 2/1/1/1, active-high sync, zero front porch
module tb_vga_area_tracker;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic       sm_hs, sm_vs, sm_vis, sm_le, sm_fe;
  logic [9:0] sm_x, sm_y;
  logic       vg_hs, vg_vs, vg_vis, vg_le, vg_fe;
  logic [9:0] vg_x, vg_y;
  logic       vt_hs, vt_vs, vt_vis, vt_le, vt_fe;
  logic [9:0] vt_x, vt_y;
  logic       sa_hs, sa_vs, sa_vis, sa_le, sa_fe;
  logic [9:0] sa_x, sa_y;

  vga_area_tracker #(
    .CNT_WIDTH(10), .H_VISIBLE(1), .H_FRONT_PORCH(4), .H_SYNC(3), .H_BACK_PORCH(2),
    .V_VISIBLE(2), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1), .SYNC_ACTIVE(1'b0)
  ) u_small (
    .i_clk(clk), .i_rst(rst), .o_h_sync(sm_hs), .o_v_sync(sm_vs), .o_visible(sm_vis),
    .o_x(sm_x), .o_y(sm_y), .o_line_end(sm_le), .o_frame_end(sm_fe)
  );

  vga_area_tracker u_vga (
    .i_clk(clk), .i_rst(rst), .o_h_sync(vg_hs), .o_v_sync(vg_vs), .o_visible(vg_vis),
    .o_x(vg_x), .o_y(vg_y), .o_line_end(vg_le), .o_frame_end(vg_fe)
  );

  vga_area_tracker #(
    .H_VISIBLE(1), .H_FRONT_PORCH(0), .H_SYNC(1), .H_BACK_PORCH(0)
  ) u_vtall (
    .i_clk(clk), .i_rst(rst), .o_h_sync(vt_hs), .o_v_sync(vt_vs), .o_visible(vt_vis),
    .o_x(vt_x), .o_y(vt_y), .o_line_end(vt_le), .o_frame_end(vt_fe)
  );

  vga_area_tracker #(
    .CNT_WIDTH(10), .H_VISIBLE(4), .H_FRONT_PORCH(0), .H_SYNC(3), .H_BACK_PORCH(2),
    .V_VISIBLE(2), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1), .SYNC_ACTIVE(1'b1)
  ) u_sa (
    .i_clk(clk), .i_rst(rst), .o_h_sync(sa_hs), .o_v_sync(sa_vs), .o_visible(sa_vis),
    .o_x(sa_x), .o_y(sa_y), .o_line_end(sa_le), .o_frame_end(sa_fe)
  );

  // Reset is applied and released on falling edges, so on return every
  // instance sits at (0,0) with the next rising edge about to move h to 1.
  task automatic doReset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // While reset is held, every instance must show the (0,0) decode.
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++; if (sm_hs !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_sm_hsync: got %b expected 1", sm_hs); end
    compared++; if (sm_vs !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_sm_vsync: got %b expected 1", sm_vs); end
    compared++; if (sm_vis !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_sm_visible: got %b expected 1", sm_vis); end
    compared++; if (sm_x !== 10'd0 || sm_y !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_sm_xy: got %0d,%0d expected 0,0", sm_x, sm_y); end
    compared++; if (sm_le !== 1'b0 || sm_fe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sm_ends: got %b%b expected 00", sm_le, sm_fe); end
    compared++; if (vg_hs !== 1'b1 || vg_vs !== 1'b1 || vg_vis !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_vga: got hs%b vs%b vis%b expected 1 1 1", vg_hs, vg_vs, vg_vis); end
    compared++; if (sa_hs !== 1'b0 || sa_vs !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sa_syncs: got %b%b expected 00", sa_hs, sa_vs); end
    compared++; if (sa_vis !== 1'b1 || sa_x !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_sa_vis: got vis%b x%0d expected vis1 x0", sa_vis, sa_x); end
    rst = 1'b0;
  endtask

  // Two lines of the 10-pixel configuration: hsync low at 5,6,7 only,
  // line end at 9 only, visible only at h=0 (both lines are visible).
  task automatic test_hsync_line;
    logic [9:0] expHs;
    int h, v;
    expHs = 10'b1100011111;
    doReset();
    for (int c = 0; c < 20; c++) begin
      h = c % 10;
      v = c / 10;
      compared++; if (sm_hs !== expHs[h]) begin mismatched++; $display("[TB] FAIL line_hsync c=%0d: got %b expected %b", c, sm_hs, expHs[h]); end
      compared++; if (sm_le !== (h == 9)) begin mismatched++; $display("[TB] FAIL line_end c=%0d: got %b expected %b", c, sm_le, (h == 9)); end
      compared++; if (sm_vis !== (h == 0)) begin mismatched++; $display("[TB] FAIL line_visible c=%0d: got %b expected %b", c, sm_vis, (h == 0)); end
      compared++; if (sm_y !== ((h == 0) ? 10'(v) : 10'd0)) begin mismatched++; $display("[TB] FAIL line_y c=%0d: got %0d expected %0d", c, sm_y, (h == 0) ? v : 0); end
      @(negedge clk);
    end
  endtask

  // Two full frames of the small configuration: line 3 carries vsync,
  // visible only on lines 0-1, frame end on clocks 49 and 99.
  task automatic test_vsync_frame;
    int h, v, frames;
    frames = 0;
    doReset();
    for (int c = 0; c < 100; c++) begin
      h = c % 10;
      v = (c / 10) % 5;
      if (sm_fe === 1'b1) frames++;
      compared++; if (sm_vs !== (v != 3)) begin mismatched++; $display("[TB] FAIL frame_vsync c=%0d: got %b expected %b", c, sm_vs, (v != 3)); end
      compared++; if (sm_fe !== (c % 50 == 49)) begin mismatched++; $display("[TB] FAIL frame_end c=%0d: got %b expected %b", c, sm_fe, (c % 50 == 49)); end
      compared++; if (sm_vis !== (h == 0 && v < 2)) begin mismatched++; $display("[TB] FAIL frame_visible c=%0d: got %b expected %b", c, sm_vis, (h == 0 && v < 2)); end
      @(negedge clk);
    end
    compared++; if (frames != 2) begin mismatched++; $display("[TB] FAIL frame_count: got %0d expected 2", frames); end
  endtask

  // Reset asserted between edges while h=6 (inside the sync pulse) must
  // take effect without a clock edge, then the raster restarts from (0,0).
  task automatic test_async_reset;
    doReset();
    repeat (6) @(negedge clk);
    compared++; if (sm_hs !== 1'b0) begin mismatched++; $display("[TB] FAIL async_pre_hsync: got %b expected 0", sm_hs); end
    compared++; if (sa_hs !== 1'b1) begin mismatched++; $display("[TB] FAIL async_pre_sa_hsync: got %b expected 1", sa_hs); end
    #2 rst = 1'b1;
    #1;
    compared++; if (sm_hs !== 1'b1) begin mismatched++; $display("[TB] FAIL async_hsync: got %b expected 1", sm_hs); end
    compared++; if (sm_vis !== 1'b1 || sm_x !== 10'd0 || sm_y !== 10'd0) begin mismatched++; $display("[TB] FAIL async_pos: got vis%b x%0d y%0d expected vis1 x0 y0", sm_vis, sm_x, sm_y); end
    compared++; if (sa_hs !== 1'b0) begin mismatched++; $display("[TB] FAIL async_sa_hsync: got %b expected 0", sa_hs); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++; if (sm_vis !== 1'b0 || sm_hs !== 1'b1) begin mismatched++; $display("[TB] FAIL async_restart_h1: got vis%b hs%b expected vis0 hs1", sm_vis, sm_hs); end
    repeat (4) @(negedge clk);
    compared++; if (sm_hs !== 1'b0) begin mismatched++; $display("[TB] FAIL async_restart_h5: got %b expected 0", sm_hs); end
    repeat (4) @(negedge clk);
    compared++; if (sm_le !== 1'b1 || sm_fe !== 1'b0) begin mismatched++; $display("[TB] FAIL async_restart_h9: got le%b fe%b expected le1 fe0", sm_le, sm_fe); end
  endtask

  // Default 640x480 horizontal timing over two lines: 800-pixel period,
  // hsync low at 656..751, x tracks h in the visible region.
  task automatic test_vga_horizontal;
    int h, v;
    logic expVis;
    doReset();
    for (int c = 0; c < 1600; c++) begin
      h = c % 800;
      v = c / 800;
      expVis = (h < 640);
      compared++; if (vg_hs !== !(h >= 656 && h <= 751)) begin mismatched++; $display("[TB] FAIL vga_hsync c=%0d: got %b expected %b", c, vg_hs, !(h >= 656 && h <= 751)); end
      compared++; if (vg_le !== (h == 799)) begin mismatched++; $display("[TB] FAIL vga_line_end c=%0d: got %b expected %b", c, vg_le, (h == 799)); end
      compared++; if (vg_vis !== expVis) begin mismatched++; $display("[TB] FAIL vga_visible c=%0d: got %b expected %b", c, vg_vis, expVis); end
      compared++; if (vg_x !== (expVis ? 10'(h) : 10'd0) || vg_y !== (expVis ? 10'(v) : 10'd0)) begin mismatched++; $display("[TB] FAIL vga_xy c=%0d: got %0d,%0d expected %0d,%0d", c, vg_x, vg_y, expVis ? h : 0, expVis ? v : 0); end
      compared++; if (vg_vs !== 1'b1 || vg_fe !== 1'b0) begin mismatched++; $display("[TB] FAIL vga_vsync c=%0d: got vs%b fe%b expected vs1 fe0", c, vg_vs, vg_fe); end
      @(negedge clk);
    end
  endtask

  // Default vertical timing on a 2-pixel line: 525-line frame, vsync low on
  // lines 490..491, and hsync directly after the single visible pixel.
  task automatic test_vga_vertical;
    int h, v;
    doReset();
    for (int c = 0; c < 1052; c++) begin
      h = c % 2;
      v = (c / 2) % 525;
      compared++; if (vt_vs !== !(v >= 490 && v <= 491)) begin mismatched++; $display("[TB] FAIL vt_vsync c=%0d: got %b expected %b", c, vt_vs, !(v >= 490 && v <= 491)); end
      compared++; if (vt_hs !== (h == 0)) begin mismatched++; $display("[TB] FAIL vt_hsync c=%0d: got %b expected %b", c, vt_hs, (h == 0)); end
      compared++; if (vt_fe !== (c == 1049)) begin mismatched++; $display("[TB] FAIL vt_frame_end c=%0d: got %b expected %b", c, vt_fe, (c == 1049)); end
      compared++; if (vt_vis !== (h == 0 && v < 480)) begin mismatched++; $display("[TB] FAIL vt_visible c=%0d: got %b expected %b", c, vt_vis, (h == 0 && v < 480)); end
      @(negedge clk);
    end
  endtask

  // Active-high sync with zero front porch: hsync high at h=4,5,6 (starting
  // right at H_VISIBLE), low elsewhere; vsync high on line 3 only.
  task automatic test_sync_active_high;
    logic [8:0] expHs;
    int h, v;
    expHs = 9'b001110000;
    doReset();
    for (int c = 0; c < 54; c++) begin
      h = c % 9;
      v = (c / 9) % 5;
      compared++; if (sa_hs !== expHs[h]) begin mismatched++; $display("[TB] FAIL sa_hsync c=%0d: got %b expected %b", c, sa_hs, expHs[h]); end
      compared++; if (sa_vs !== (v == 3)) begin mismatched++; $display("[TB] FAIL sa_vsync c=%0d: got %b expected %b", c, sa_vs, (v == 3)); end
      compared++; if (sa_x !== ((h < 4 && v < 2) ? 10'(h) : 10'd0)) begin mismatched++; $display("[TB] FAIL sa_x c=%0d: got %0d expected %0d", c, sa_x, (h < 4 && v < 2) ? h : 0); end
      compared++; if (sa_fe !== (c == 44)) begin mismatched++; $display("[TB] FAIL sa_frame_end c=%0d: got %b expected %b", c, sa_fe, (c == 44)); end
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] vga_area_tracker directed tests starting");
    test_reset();
    test_hsync_line();
    test_vsync_frame();
    test_async_reset();
    test_vga_horizontal();
    test_vga_vertical();
    test_sync_active_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
